booth_pp_accumulator: RTL and testbench

// - Sequential reduction stage downstream of the radix-4 Booth PP generator (booth_alg).
// - Captures one set of 16 Booth rows (PP0..PP15), the unsigned-fixup row PP16 and the error_correction bits.
// - Sums them over multiple cycles into a 64-bit product. A valid/ready handshake is used on both input and output.
// - Trades area for latency: ROWS_PER_CYCLE shifted rows are added per cycle.

---
 rtl/booth_pp_accumulator.sv | 161 ++++++++++++++++
 tb/tb_booth_pp_accumulator.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_pp_accumulator.sv
// booth_pp_accumulator: multi-cycle reduction of radix-4 Booth partial-product
// rows (PP0..PP15, PP16 fixup row, error_correction bits) into a 64-bit product.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   input handshake; one row set accepted per transfer
//   pp_rows[543:0]      {PP15..PP0}, 34-bit rows, sign-extended when summed
//   pp_msb[31:0]        PP16, zero-extended, weight 2^32
//   error_correction    bit i adds +1 at weight 2^(2i)
//   out_valid/out_ready output handshake; product held while stalled
//   product[63:0]       accumulated sum (mod 2^64)
//   busy                high whenever the block is not idle
//
// Parameter ROWS_PER_CYCLE (1,2,4,8,16): rows summed per ACC cycle.
// Optional macro PP_ACC_EARLY_EN: skip ACC cycles once all remaining rows
// and their correction bits are zero.
module booth_pp_accumulator #(
    parameter int ROWS_PER_CYCLE = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [543:0] pp_rows,
    input  logic [31:0]  pp_msb,
    input  logic [15:0]  error_correction,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  product,
    output logic         busy
);

    localparam int NSTEP = 16 / ROWS_PER_CYCLE;
    localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSTEP - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [33:0]   rows_q [16];
    logic [63:0]   acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          load;
    logic [63:0]   ec_spread;
    logic [63:0]   init_sum;
    logic [63:0]   step_sum;
    logic [3:0]    row_idx;
    logic [63:0]   row_ext;
    logic          early_in;
    logic          early_acc;

    // Correction bits and PP16 occupy disjoint bit ranges, so they are
    // folded into the accumulator at accept time in one add.
    always_comb begin
        ec_spread = '0;
        for (int i = 0; i < 16; i++) begin
            ec_spread[2*i] = error_correction[i];
        end
    end

    assign init_sum = {pp_msb, 32'b0} + ec_spread;

    // Rows cnt*R .. cnt*R+R-1, each sign-extended and weighted by 4^index.
    always_comb begin
        step_sum = acc_q;
        row_idx  = '0;
        row_ext  = '0;
        for (int j = 0; j < ROWS_PER_CYCLE; j++) begin
            row_idx  = 4'(int'(cnt_q) * ROWS_PER_CYCLE + j);
            row_ext  = {{30{rows_q[row_idx][33]}}, rows_q[row_idx]};
            step_sum = step_sum + (row_ext << (2 * row_idx));
        end
    end

`ifdef PP_ACC_EARLY_EN
    logic [15:0] ec_q;
    logic [15:0] row_nz;
    logic [15:0] rest_mask;

    always_comb begin
        row_nz = '0;
        for (int i = 0; i < 16; i++) begin
            row_nz[i] = (|rows_q[i]) | ec_q[i];
        end
    end

    // Rows still pending after the add performed this cycle.
    assign rest_mask = row_nz >> ((int'(cnt_q) + 1) * ROWS_PER_CYCLE);
    assign early_in  = ~|pp_rows & ~|error_correction;
    assign early_acc = ~|rest_mask;
`else
    assign early_in  = 1'b0;
    assign early_acc = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    load    = 1'b1;
                    acc_d   = init_sum;
                    cnt_d   = '0;
                    state_d = early_in ? DONE : ACC;
                end
            end
            ACC: begin
                acc_d = step_sum;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST || early_acc) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < 16; i++) begin
                rows_q[i] <= '0;
            end
`ifdef PP_ACC_EARLY_EN
            ec_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            if (load) begin
                for (int i = 0; i < 16; i++) begin
                    rows_q[i] <= pp_rows[34*i +: 34];
                end
`ifdef PP_ACC_EARLY_EN
                ec_q <= error_correction;
`endif
            end
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign product   = acc_q;

endmodule

// File: tb/tb_booth_pp_accumulator.sv
// tb_booth_pp_accumulator: vector table, handshake/reset sequences, random
// multiplies and a ROWS_PER_CYCLE sweep, all checked against a*b.
module tb_booth_pp_accumulator;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [543:0] pp_rows;
    logic [31:0]  pp_msb;
    logic [15:0]  error_correction;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  product;
    logic         busy;

    logic         sw_valid;
    logic [543:0] sw_rows;
    logic [31:0]  sw_msb;
    logic [15:0]  sw_ec;
    logic         sw_ir   [4];
    logic         sw_ov   [4];
    logic [63:0]  sw_prod [4];
    logic         sw_busy [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    booth_pp_accumulator #(.ROWS_PER_CYCLE(2)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .pp_rows(pp_rows),
        .pp_msb(pp_msb),
        .error_correction(error_correction),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .product(product),
        .busy(busy)
    );

    // Sweep instances: R = 1, 4, 8, 16
    for (genvar g = 0; g < 4; g++) begin : g_sw
        booth_pp_accumulator #(
            .ROWS_PER_CYCLE(1 << ((g == 0) ? 0 : g + 1))
        ) u_sw (
            .clk(clk),
            .rst(rst),
            .in_valid(sw_valid),
            .in_ready(sw_ir[g]),
            .pp_rows(sw_rows),
            .pp_msb(sw_msb),
            .error_correction(sw_ec),
            .out_valid(sw_ov[g]),
            .out_ready(1'b1),
            .product(sw_prod[g]),
            .busy(sw_busy[g])
        );
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        bit          sgn;
        logic [63:0] exp;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Radix-4 Booth row generator (stimulus side): negative digits are
    // delivered as inverted magnitude plus a +1 correction bit.
    function automatic void booth(input logic [31:0] a, input logic [31:0] b,
                                  input bit sgn, output logic [543:0] rows,
                                  output logic [31:0] msb,
                                  output logic [15:0] ec);
        logic [63:0] av;
        logic [63:0] mag;
        logic [32:0] bx;
        int d;
        rows = '0;
        ec   = '0;
        av   = sgn ? {{32{a[31]}}, a} : {32'b0, a};
        bx   = {b, 1'b0};
        for (int i = 0; i < 16; i++) begin
            d = (bx[2*i+1] ? 1 : 0) + (bx[2*i] ? 1 : 0) - (bx[2*i+2] ? 2 : 0);
            if (d == 0) mag = 64'd0;
            else if (d == 2 || d == -2) mag = av << 1;
            else mag = av;
            if (d < 0) begin
                rows[34*i +: 34] = ~mag[33:0];
                ec[i] = 1'b1;
            end else begin
                rows[34*i +: 34] = mag[33:0];
            end
        end
        msb = (!sgn && b[31]) ? a : 32'd0;
    endfunction

    function automatic logic [63:0] ref_mul(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input bit sgn);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        if (sgn) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
            return sa * sb;
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    // Cycles from accept edge to the first sample showing out_valid.
    function automatic int exp_lat(input logic [543:0] rows,
                                   input logic [15:0] ec, input int r);
`ifdef PP_ACC_EARLY_EN
        bit rest;
        if (rows == '0 && ec == '0) return 1;
        for (int k = 0; k < 16 / r; k++) begin
            rest = 1'b1;
            for (int i = (k + 1) * r; i < 16; i++) begin
                if (rows[34*i +: 34] != 34'd0 || ec[i]) rest = 1'b0;
            end
            if (rest) return k + 2;
        end
`endif
        return 16 / r + 1;
    endfunction

    // Called at a negedge; returns just after the accept edge.
    task automatic start(input logic [543:0] r, input logic [31:0] m,
                         input logic [15:0] e);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", 64'(in_ready), 64'd1);
        in_valid         = 1'b1;
        pp_rows          = r;
        pp_msb           = m;
        error_correction = e;
        @(posedge clk);
        #1;
        in_valid         = 1'b0;
        pp_rows          = {17{$urandom()}};
        pp_msb           = $urandom();
        error_correction = 16'($urandom());
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                chk("busy_after_accept", 64'(busy), 64'd1);
                chk("in_ready_after_accept", 64'(in_ready), 64'd0);
            end
        end while (!out_valid && lat < 40);
        chk("out_valid_timeout", 64'(out_valid), 64'd1);
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         input bit sgn, input logic [63:0] exp_p);
        logic [543:0] r;
        logic [31:0]  m;
        logic [15:0]  e;
        int lat;
        booth(a, b, sgn, r, m, e);
        start(r, m, e);
        wait_done(lat);
        chk("latency", 64'(lat), 64'(exp_lat(r, e, 2)));
        chk("product", product, exp_p);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         vecs [8];
        logic [543:0] r;
        logic [31:0]  m;
        logic [15:0]  e;
        logic [63:0]  ex;
        logic [31:0]  a;
        logic [31:0]  b;
        bit           sgn;
        int           lat;
        bit           seen [4];

        vecs[0] = '{32'd3,        32'd5,        1'b0, 64'h000000000000000F};
        vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001};
        vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h0000000000000001};
        vecs[3] = '{32'h80000000, 32'h7FFFFFFF, 1'b1, 64'hC000000080000000};
        vecs[4] = '{32'h7FFFFFFF, 32'h80000000, 1'b0, 64'h3FFFFFFF80000000};
        vecs[5] = '{32'h12345678, 32'd0,        1'b0, 64'h0000000000000000};
        vecs[6] = '{32'h12345678, 32'd3,        1'b0, 64'h00000000369D0368};
        vecs[7] = '{32'd7,        32'd6,        1'b1, 64'd42};

        rst              = 1'b1;
        in_valid         = 1'b0;
        out_ready        = 1'b1;
        pp_rows          = '0;
        pp_msb           = '0;
        error_correction = '0;
        sw_valid         = 1'b0;
        sw_rows          = '0;
        sw_msb           = '0;
        sw_ec            = '0;

        #12;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_product", product, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].exp);
        end

        // Backpressure: hold DONE for 5 cycles with in_valid pulses.
        @(negedge clk);
        out_ready = 1'b0;
        ex = ref_mul(32'd1234567, 32'd89, 1'b0);
        booth(32'd1234567, 32'd89, 1'b0, r, m, e);
        start(r, m, e);
        wait_done(lat);
        chk("bp_product", product, ex);
        for (int k = 0; k < 5; k++) begin
            in_valid         = k[0] ? 1'b0 : 1'b1;
            pp_rows          = {17{$urandom()}};
            error_correction = 16'hFFFF;
            @(negedge clk);
            chk("bp_out_valid_held", 64'(out_valid), 64'd1);
            chk("bp_product_held", product, ex);
            chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_released_valid", 64'(out_valid), 64'd0);
        chk("bp_released_ready", 64'(in_ready), 64'd1);
        repeat (3) @(negedge clk);
        chk("bp_no_second_out", 64'(out_valid), 64'd0);
        chk("bp_idle", 64'(busy), 64'd0);
        out_ready = 1'b1;

        // Asynchronous reset in the middle of ACC.
        booth(32'hDEADBEEF, 32'h12345678, 1'b1, r, m, e);
        start(r, m, e);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_product", product, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_op(32'd7, 32'd6, 1'b0, 64'd42);

        // Random pairs against a plain multiply.
        for (int i = 0; i < 1500; i++) begin
            a   = $urandom();
            b   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15))
                                              : $urandom();
            sgn = 1'($urandom_range(0, 1));
            do_op(a, b, sgn, ref_mul(a, b, sgn));
        end

        // ROWS_PER_CYCLE sweep on the side instances.
        for (int v = 0; v < 30; v++) begin
            int n;
            a   = $urandom();
            b   = (v % 5 == 0) ? 32'($urandom_range(0, 7)) : $urandom();
            sgn = 1'(v % 2);
            booth(a, b, sgn, r, m, e);
            ex = ref_mul(a, b, sgn);
            n  = 0;
            while (!(sw_ir[0] && sw_ir[1] && sw_ir[2] && sw_ir[3]) && n < 40) begin
                @(negedge clk);
                n++;
            end
            sw_valid = 1'b1;
            sw_rows  = r;
            sw_msb   = m;
            sw_ec    = e;
            @(posedge clk);
            #1;
            sw_valid = 1'b0;
            sw_rows  = '1;
            sw_msb   = '1;
            sw_ec    = '1;
            for (int k = 0; k < 4; k++) seen[k] = 1'b0;
            for (int c = 1; c <= 20; c++) begin
                @(negedge clk);
                for (int k = 0; k < 4; k++) begin
                    if (!seen[k] && sw_ov[k]) begin
                        seen[k] = 1'b1;
                        chk("sweep_latency", 64'(c),
                            64'(exp_lat(r, e, 1 << ((k == 0) ? 0 : k + 1))));
                        chk("sweep_product", sw_prod[k], ex);
                    end
                end
            end
            for (int k = 0; k < 4; k++) begin
                chk("sweep_done", 64'(seen[k]), 64'd1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
